// File: rtl/zz_buf_ctrl.sv
// Ping-pong 8x8 coefficient buffer controller: zigzag-order writes into the free
// bank, raster-order reads from the full bank through a 2-entry output FIFO.
module zz_buf_ctrl #(
  parameter int W      = 12,
  parameter bit ZIGZAG = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic [W-1:0] mem_S_in,
  output logic [6:0]   mem_waddr,
  output logic         mem_wren,
  output logic [6:0]   mem_raddr,
  input  logic [W-1:0] mem_S_out
);

  logic [1:0]        full_q, full_d;
  logic              wbank_q, wbank_d;
  logic              rbank_q, rbank_d;
  logic [5:0]        wcnt_q, wcnt_d;
  logic [5:0]        rcnt_q, rcnt_d;
  logic              inflight_q, inflight_d;
  logic              inflight_last_q, inflight_last_d;
  logic [1:0][W-1:0] fifo_data_q, fifo_data_d;
  logic [1:0]        fifo_last_q, fifo_last_d;
  logic              fifo_wptr_q, fifo_wptr_d;
  logic              fifo_rptr_q, fifo_rptr_d;
  logic [1:0]        fifo_cnt_q, fifo_cnt_d;

  logic [5:0] zz_nat;
  logic [5:0] wr_nat;
  logic       wr_en;
  logic       pop;
  logic       issue;
  logic [2:0] occ;

  // zigzag position -> natural (row*8+col) index
  always_comb begin
    zz_nat = 6'd0;
    case (wcnt_q)
      6'd0:  zz_nat = 6'd0;  6'd1:  zz_nat = 6'd1;  6'd2:  zz_nat = 6'd8;  6'd3:  zz_nat = 6'd16;
      6'd4:  zz_nat = 6'd9;  6'd5:  zz_nat = 6'd2;  6'd6:  zz_nat = 6'd3;  6'd7:  zz_nat = 6'd10;
      6'd8:  zz_nat = 6'd17; 6'd9:  zz_nat = 6'd24; 6'd10: zz_nat = 6'd32; 6'd11: zz_nat = 6'd25;
      6'd12: zz_nat = 6'd18; 6'd13: zz_nat = 6'd11; 6'd14: zz_nat = 6'd4;  6'd15: zz_nat = 6'd5;
      6'd16: zz_nat = 6'd12; 6'd17: zz_nat = 6'd19; 6'd18: zz_nat = 6'd26; 6'd19: zz_nat = 6'd33;
      6'd20: zz_nat = 6'd40; 6'd21: zz_nat = 6'd48; 6'd22: zz_nat = 6'd41; 6'd23: zz_nat = 6'd34;
      6'd24: zz_nat = 6'd27; 6'd25: zz_nat = 6'd20; 6'd26: zz_nat = 6'd13; 6'd27: zz_nat = 6'd6;
      6'd28: zz_nat = 6'd7;  6'd29: zz_nat = 6'd14; 6'd30: zz_nat = 6'd21; 6'd31: zz_nat = 6'd28;
      6'd32: zz_nat = 6'd35; 6'd33: zz_nat = 6'd42; 6'd34: zz_nat = 6'd49; 6'd35: zz_nat = 6'd56;
      6'd36: zz_nat = 6'd57; 6'd37: zz_nat = 6'd50; 6'd38: zz_nat = 6'd43; 6'd39: zz_nat = 6'd36;
      6'd40: zz_nat = 6'd29; 6'd41: zz_nat = 6'd22; 6'd42: zz_nat = 6'd15; 6'd43: zz_nat = 6'd23;
      6'd44: zz_nat = 6'd30; 6'd45: zz_nat = 6'd37; 6'd46: zz_nat = 6'd44; 6'd47: zz_nat = 6'd51;
      6'd48: zz_nat = 6'd58; 6'd49: zz_nat = 6'd59; 6'd50: zz_nat = 6'd52; 6'd51: zz_nat = 6'd45;
      6'd52: zz_nat = 6'd38; 6'd53: zz_nat = 6'd31; 6'd54: zz_nat = 6'd39; 6'd55: zz_nat = 6'd46;
      6'd56: zz_nat = 6'd53; 6'd57: zz_nat = 6'd60; 6'd58: zz_nat = 6'd61; 6'd59: zz_nat = 6'd54;
      6'd60: zz_nat = 6'd47; 6'd61: zz_nat = 6'd55; 6'd62: zz_nat = 6'd62; 6'd63: zz_nat = 6'd63;
      default: zz_nat = 6'd0;
    endcase
  end

  assign wr_nat    = ZIGZAG ? zz_nat : wcnt_q;
  assign in_ready  = !full_q[wbank_q];
  assign wr_en     = in_valid & in_ready;
  assign mem_S_in  = in_data;
  assign mem_wren  = wr_en;
  assign mem_waddr = {wbank_q, wr_nat[2:0], wr_nat[5:3]};
  assign mem_raddr = {rbank_q, rcnt_q[2:0], rcnt_q[5:3]};

  assign out_valid = (fifo_cnt_q != 2'd0);
  assign out_data  = fifo_data_q[fifo_rptr_q];
  assign out_last  = out_valid & fifo_last_q[fifo_rptr_q];
  assign pop       = out_valid & out_ready;

  // a read may only be issued if its data is guaranteed a FIFO slot on arrival
  assign occ   = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue = full_q[rbank_q] && (occ < 3'd2);

  always_comb begin
    full_d          = full_q;
    wbank_d         = wbank_q;
    rbank_d         = rbank_q;
    wcnt_d          = wcnt_q;
    rcnt_d          = rcnt_q;
    inflight_d      = issue;
    inflight_last_d = issue && (rcnt_q == 6'd63);
    if (wr_en) begin
      wcnt_d = wcnt_q + 6'd1;
      if (wcnt_q == 6'd63) begin
        full_d[wbank_q] = 1'b1;
        wbank_d         = ~wbank_q;
      end
    end
    // set and clear always hit different banks: writes need !full, reads need full
    if (issue) begin
      rcnt_d = rcnt_q + 6'd1;
      if (rcnt_q == 6'd63) begin
        full_d[rbank_q] = 1'b0;
        rbank_d         = ~rbank_q;
      end
    end
  end

  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_last_d = fifo_last_q;
    fifo_wptr_d = fifo_wptr_q;
    fifo_rptr_d = fifo_rptr_q;
    fifo_cnt_d  = fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    if (inflight_q) begin
      fifo_data_d[fifo_wptr_q] = mem_S_out;
      fifo_last_d[fifo_wptr_q] = inflight_last_q;
      fifo_wptr_d              = ~fifo_wptr_q;
    end
    if (pop) begin
      fifo_rptr_d = ~fifo_rptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q          <= 2'b00;
      wbank_q         <= 1'b0;
      rbank_q         <= 1'b0;
      wcnt_q          <= 6'd0;
      rcnt_q          <= 6'd0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      fifo_data_q     <= '0;
      fifo_last_q     <= 2'b00;
      fifo_wptr_q     <= 1'b0;
      fifo_rptr_q     <= 1'b0;
      fifo_cnt_q      <= 2'd0;
    end else begin
      full_q          <= full_d;
      wbank_q         <= wbank_d;
      rbank_q         <= rbank_d;
      wcnt_q          <= wcnt_d;
      rcnt_q          <= rcnt_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      fifo_data_q     <= fifo_data_d;
      fifo_last_q     <= fifo_last_d;
      fifo_wptr_q     <= fifo_wptr_d;
      fifo_rptr_q     <= fifo_rptr_d;
      fifo_cnt_q      <= fifo_cnt_d;
    end
  end

endmodule
